riscv_core: RTL and testbench
=============================

# riscv_core

Single-cycle RV32I integer core: fetches one instruction per clock from an external instruction memory, decodes it, executes it and retires it in the same cycle. Sits between an external instruction ROM (addressed by `pc`) and an external data memory (addressed by `alu_result`). It contains the PC, the 32×32 register file, the ALU, the immediate generator and the control decoder.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- `pc`  out  32  current instruction byte address.
- `instruction`  in  32  instruction word at `pc` (combinational fetch).
- `memwrite`  out  1  data-memory write strobe, high for store instructions.
- `alu_result`  out  32  ALU output; used as the data-memory byte address for loads and stores.
- `write_data`  out  32  store data, always equal to rs2 register value.
- `read_data`  in  32  data-memory read word at `alu_result` (combinational).

## Operation
- Supported: LUI, AUIPC, JAL, JALR, BEQ/BNE (plus BLT/BGE/BLTU/BGEU, see Configuration), LW, SW, OP-IMM (ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI), OP (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND).
- Immediates sign-extended per I/S/B/U/J formats; B/J offsets have bit 0 = 0.
- Loads: every LOAD funct3 writes the full 32-bit `read_data` to rd (no byte/half extraction).
- Stores: every STORE funct3 asserts `memwrite`, `write_data` = rs2, `alu_result` = rs1 + S-imm.
- Branches: ALU compares rs1/rs2; taken → next PC = pc + B-imm, else pc + 4. No alignment check or trap.
- JAL: rd = pc+4, next PC = pc + J-imm. JALR: rd = pc+4, next PC = (rs1 + I-imm) & ~1.
- Register file: 2 combinational read ports, 1 write port; x0 reads 0, writes ignored.
- Unknown opcode: no register write, `memwrite`=0, next PC = pc+4.
- Shift amount = low 5 bits of rs2/imm; SRAI/SRA selected by funct7[5].

## Timing
- All decode/ALU/outputs are combinational from `pc`, `instruction`, register contents and `read_data`.
- Rising `clk` edge: PC ← next PC; rd ← result if register write enabled.
- Reset low (async): PC ← `RESET_PC`, all registers ← 0, `memwrite` forced 0, register writes suppressed; held while low.
- First instruction executes in the first cycle after reset deasserts; latency 1 cycle per instruction, CPI = 1.
- Reset asserted mid-cycle aborts the instruction in flight (no register write, no store).
- PC wraps modulo 2^32.

## Configuration
- `RISCV_FULL_BRANCH_EN` defined: BLT, BGE (signed) and BLTU, BGEU (unsigned) implemented.
- Undefined: only BEQ/BNE; other branch funct3 never taken (PC+4, no side effects).

## Test plan
- Reset low 7 ns then high; instruction ANDI x1,x0,-1 (0xFFF07093) → `pc` 0 during reset, then 4, 8…; x1 = 0; `memwrite`=0.
- LW x1,1(x0) with `read_data`=32'hFFFF0000 → `alu_result`=1, `memwrite`=0, x1 = 32'hFFFF0000 after edge.
- SB/SW with rs1=x0, rs2=x1, imm=2 → `alu_result`=2, `write_data`=x1, `memwrite`=1 that cycle only.
- BEQ x1,x2,+30 with x1==x2 → next `pc` = pc+30; with x1≠x2 → pc+4; no register write.
- ADD/SUB/SRA/SLTU on x1=32'h8000_0000, x2=1 → 32'h8000_0001, 32'h7FFF_FFFF, 32'hC000_0000, 0.
- JAL x5,+16 at pc=8 → x5=12, next pc=24; ADDI x0,x0,5 → x0 still reads 0.

Source files
------------

// File: rtl/riscv_core_if.sv
// riscv_core_if: instruction-fetch and data-memory bus between the core and its memories
interface riscv_core_if;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        memwrite;
  logic [31:0] alu_result;
  logic [31:0] write_data;
  logic [31:0] read_data;
  modport master (output pc, memwrite, alu_result, write_data, input instruction, read_data);
  modport slave  (input pc, memwrite, alu_result, write_data, output instruction, read_data);
endinterface

// File: rtl/riscv_core.sv
// riscv_core: single-cycle RV32I core; define RISCV_FULL_BRANCH_EN for BLT/BGE/BLTU/BGEU
module riscv_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           reset,
  riscv_core_if.master   bus
);
  logic [31:0] pc_q, pc_d, rd_d;
  logic [31:0] regs_q [32];
  logic [31:0] ins, i_imm, s_imm, b_imm, u_imm, j_imm;
  logic [31:0] rs1_v, rs2_v, op_a, op_b, alu, pc_4;
  logic [6:0]  opcode;
  logic [4:0]  rd, shamt;
  logic [2:0]  f3, alu_op;
  logic        is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_opimm, is_op;
  logic        take, we, eq, lt, ltu;
  assign ins       = bus.instruction;
  assign opcode    = ins[6:0];
  assign rd        = ins[11:7];
  assign f3        = ins[14:12];
  assign rs1_v     = regs_q[ins[19:15]];
  assign rs2_v     = regs_q[ins[24:20]];
  assign i_imm     = {{20{ins[31]}}, ins[31:20]};
  assign s_imm     = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign b_imm     = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign u_imm     = {ins[31:12], 12'b0};
  assign j_imm     = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  assign is_lui    = opcode == 7'b0110111;
  assign is_auipc  = opcode == 7'b0010111;
  assign is_jal    = opcode == 7'b1101111;
  assign is_jalr   = opcode == 7'b1100111;
  assign is_branch = opcode == 7'b1100011;
  assign is_load   = opcode == 7'b0000011;
  assign is_store  = opcode == 7'b0100011;
  assign is_opimm  = opcode == 7'b0010011;
  assign is_op     = opcode == 7'b0110011;
  assign pc_4      = pc_q + 32'd4;
  assign eq        = rs1_v == rs2_v;
  assign lt        = $signed(rs1_v) < $signed(rs2_v);
  assign ltu       = rs1_v < rs2_v;
  // ALU: operand selection by instruction class, operation by funct3 for OP/OP-IMM, add otherwise
  always_comb begin
    op_a   = is_lui ? 32'd0 : is_auipc ? pc_q : rs1_v;
    op_b   = (is_op | is_branch) ? rs2_v : is_store ? s_imm : (is_lui | is_auipc) ? u_imm : i_imm;
    alu_op = (is_op | is_opimm) ? f3 : 3'b000;
    shamt  = op_b[4:0];
    case (alu_op)
      3'b000:  alu = ((is_op & ins[30]) | is_branch) ? op_a - op_b : op_a + op_b;
      3'b001:  alu = op_a << shamt;
      3'b010:  alu = {31'd0, $signed(op_a) < $signed(op_b)};
      3'b011:  alu = {31'd0, op_a < op_b};
      3'b100:  alu = op_a ^ op_b;
      3'b101:  alu = ins[30] ? $unsigned($signed(op_a) >>> shamt) : op_a >> shamt;
      3'b110:  alu = op_a | op_b;
      default: alu = op_a & op_b;
    endcase
  end
  // Branch decision; the signed/unsigned ordering branches exist only in the full build
  always_comb begin
`ifdef RISCV_FULL_BRANCH_EN
    take = f3 == 3'b000 ? eq : f3 == 3'b001 ? !eq : f3 == 3'b100 ? lt :
           f3 == 3'b101 ? !lt : f3 == 3'b110 ? ltu : f3 == 3'b111 ? !ltu : 1'b0;
`else
    take = f3 == 3'b000 ? eq : f3 == 3'b001 ? !eq : 1'b0 | (1'b0 & (lt | ltu));
`endif
  end
  // Next PC, write-back value and register write enable
  always_comb begin
    pc_d = is_jal ? pc_q + j_imm : is_jalr ? alu & ~32'd1 : (is_branch & take) ? pc_q + b_imm : pc_4;
    rd_d = is_load ? bus.read_data : (is_jal | is_jalr) ? pc_4 : alu;
    we   = (is_lui | is_auipc | is_jal | is_jalr | is_load | is_opimm | is_op) & (rd != 5'd0);
  end
  assign bus.pc         = pc_q;
  assign bus.alu_result = alu;
  assign bus.write_data = rs2_v;
  assign bus.memwrite   = is_store & reset;
  // PC and register file; reset clears everything and blocks writes while held low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      pc_q <= pc_d;
      if (we) regs_q[rd] <= rd_d;
    end
  end
endmodule

// File: tb/tb_riscv_core.sv
// tb_riscv_core: directed-vector bench for riscv_core
module tb_riscv_core;
  logic clk = 1'b0;
  logic reset;
  int errs = 0, checks = 0;
  logic [31:0] exp_pc;
  riscv_core_if bus ();
  riscv_core dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction
  task automatic set(input logic [31:0] ins, input logic [31:0] rdat = 32'd0);
    bus.instruction = ins;
    bus.read_data   = rdat;
    #1;
  endtask
  task automatic step(input string tag);
    @(negedge clk);
    #1;
    check(tag, bus.pc, exp_pc);
  endtask
  task automatic peek(input logic [4:0] r, input logic [31:0] e, input string tag);
    logic [31:0] saved;
    saved = bus.instruction;
    bus.instruction = enc_s(12'd0, r, 5'd0, 3'd2);
    #1;
    check(tag, bus.write_data, e);
    bus.instruction = saved;
  endtask
  task automatic run(input logic [31:0] ins, input logic [31:0] alu_exp, input string tag);
    set(ins);
    check(tag, bus.alu_result, alu_exp);
    exp_pc = exp_pc + 32'd4;
    step({tag, "_pc"});
  endtask
  initial begin
    reset = 1'b0;
    bus.instruction = 32'hFFF07093;
    bus.read_data = 32'd0;
    exp_pc = 32'd0;
    #1;
    check("rst_pc", bus.pc, 32'd0);
    bus.instruction = enc_s(12'd2, 5'd1, 5'd0, 3'd2);
    #1;
    check("rst_memwrite", {31'd0, bus.memwrite}, 32'd0);
    bus.instruction = 32'hFFF07093;
    #5 reset = 1'b1;
    @(negedge clk);
    #1;
    check("pc_first", bus.pc, 32'd0);
    exp_pc = 32'd4;  step("pc_andi0");
    exp_pc = 32'd8;  step("pc_andi1");
    peek(5'd1, 32'd0, "x1_andi");
    set(enc_i(12'd1, 5'd0, 3'd2, 5'd1, 7'h03), 32'hFFFF0000);
    check("lw_addr", bus.alu_result, 32'd1);
    check("lw_mw", {31'd0, bus.memwrite}, 32'd0);
    exp_pc = 32'd12; step("lw_pc");
    peek(5'd1, 32'hFFFF0000, "x1_lw");
    set(enc_s(12'd2, 5'd1, 5'd0, 3'd2));
    check("sw_addr", bus.alu_result, 32'd2);
    check("sw_data", bus.write_data, 32'hFFFF0000);
    check("sw_mw", {31'd0, bus.memwrite}, 32'd1);
    exp_pc = 32'd16; step("sw_pc");
    set(enc_i(12'd5, 5'd0, 3'd0, 5'd0, 7'h13));
    check("mw_after_sw", {31'd0, bus.memwrite}, 32'd0);
    exp_pc = 32'd20; step("addi_x0_pc");
    peek(5'd0, 32'd0, "x0_zero");
    set(enc_s(12'd2, 5'd1, 5'd0, 3'd0));
    check("sb_mw", {31'd0, bus.memwrite}, 32'd1);
    check("sb_addr", bus.alu_result, 32'd2);
    exp_pc = 32'd24; step("sb_pc");
    run({20'h80000, 5'd1, 7'h37}, 32'h80000000, "lui");
    run(enc_i(12'd1, 5'd0, 3'd0, 5'd2, 7'h13), 32'd1, "addi");
    run(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'h80000001, "add");
    peek(5'd3, 32'h80000001, "x3_add");
    run(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3), 32'h7FFFFFFF, "sub");
    run(enc_r(7'h20, 5'd2, 5'd1, 3'd5, 5'd3), 32'hC0000000, "sra");
    peek(5'd3, 32'hC0000000, "x3_sra");
    run(enc_r(7'h00, 5'd2, 5'd1, 3'd5, 5'd3), 32'h40000000, "srl");
    run(enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd3), 32'd0, "sltu");
    run(enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd3), 32'd1, "slt");
    run(enc_r(7'h00, 5'd2, 5'd1, 3'd1, 5'd3), 32'd0, "sll");
    run(enc_i(12'h404, 5'd1, 3'd5, 5'd4, 7'h13), 32'hF8000000, "srai");
    run(enc_i(12'h004, 5'd1, 3'd5, 5'd4, 7'h13), 32'h08000000, "srli");
    run(enc_i(12'hFFF, 5'd1, 3'd4, 5'd4, 7'h13), 32'h7FFFFFFF, "xori");
    run(enc_i(12'hFFF, 5'd2, 3'd3, 5'd4, 7'h13), 32'd1, "sltiu");
    peek(5'd4, 32'd1, "x4_sltiu");
    set(enc_b(13'd30, 5'd2, 5'd1, 3'd0));
    exp_pc = exp_pc + 32'd4; step("beq_nt");
    run(enc_i(12'd0, 5'd1, 3'd0, 5'd2, 7'h13), 32'h80000000, "mv");
    set(enc_b(13'd30, 5'd2, 5'd1, 3'd0));
    exp_pc = exp_pc + 32'd30; step("beq_t");
    peek(5'd30, 32'd0, "beq_no_wr");
    set(enc_b(13'd30, 5'd2, 5'd1, 3'd1));
    exp_pc = exp_pc + 32'd4; step("bne_nt");
    run(enc_i(12'd1, 5'd0, 3'd0, 5'd2, 7'h13), 32'd1, "x2_1");
    set(enc_b(13'd8, 5'd2, 5'd1, 3'd4));
`ifdef RISCV_FULL_BRANCH_EN
    exp_pc = exp_pc + 32'd8; step("blt");
`else
    exp_pc = exp_pc + 32'd4; step("blt");
`endif
    set(enc_b(13'd8, 5'd2, 5'd1, 3'd6));
    exp_pc = exp_pc + 32'd4; step("bltu_nt");
    set(enc_b(13'd8, 5'd2, 5'd1, 3'd7));
`ifdef RISCV_FULL_BRANCH_EN
    exp_pc = exp_pc + 32'd8; step("bgeu");
`else
    exp_pc = exp_pc + 32'd4; step("bgeu");
`endif
    set(enc_i(12'd8, 5'd0, 3'd0, 5'd0, 7'h67));
    exp_pc = 32'd8; step("jalr_to8");
    set(enc_j(21'd16, 5'd5));
    exp_pc = 32'd24; step("jal_pc");
    peek(5'd5, 32'd12, "jal_link");
    set(enc_i(12'd5, 5'd0, 3'd0, 5'd6, 7'h67));
    exp_pc = 32'd4; step("jalr_pc");
    peek(5'd6, 32'd28, "jalr_link");
    run({20'h00001, 5'd7, 7'h17}, 32'h00001004, "auipc");
    peek(5'd7, 32'h00001004, "x7_auipc");
    set(32'hFFFFFFFF);
    check("unk_mw", {31'd0, bus.memwrite}, 32'd0);
    exp_pc = exp_pc + 32'd4; step("unk_pc");
    peek(5'd31, 32'd0, "unk_no_wr");
    set(enc_i(12'hFFC, 5'd0, 3'd0, 5'd0, 7'h67));
    exp_pc = 32'hFFFFFFFC; step("jalr_top");
    set(enc_i(12'd0, 5'd0, 3'd0, 5'd0, 7'h13));
    exp_pc = 32'd0; step("pc_wrap");
    exp_pc = 32'd4; step("pc_after_wrap");
    set(enc_s(12'd2, 5'd1, 5'd0, 3'd2));
    check("mid_mw_pre", {31'd0, bus.memwrite}, 32'd1);
    reset = 1'b0;
    #1;
    check("mid_mw", {31'd0, bus.memwrite}, 32'd0);
    check("mid_pc", bus.pc, 32'd0);
    peek(5'd1, 32'd0, "mid_regs_clr");
    bus.instruction = enc_i(12'd0, 5'd0, 3'd0, 5'd0, 7'h13);
    reset = 1'b1;
    exp_pc = 32'd4; step("post_rst_pc");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
